// File: rtl/mac_sequencer.sv
// Sequences one MAC job: clear the MAC, stream operand beats, drain the product
// register, capture the accumulator and hold it until the result is accepted.
module mac_sequencer #(
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             job_valid,
  output logic             job_ready,
  input  logic [1:0]       job_prec,
  input  logic [LEN_W-1:0] job_len,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [7:0]       op_act,
  input  logic [7:0]       op_wgt,
  output logic             mac_en,
  output logic             mac_clr,
  output logic [1:0]       mac_prec,
  output logic [7:0]       mac_act,
  output logic [7:0]       mac_wgt,
  input  logic [55:0]      mac_result,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [55:0]      res_data,
  output logic [1:0]       res_prec,
  output logic             res_err,
  output logic             busy
);

  // state | meaning
  // IDLE  | waiting for a job descriptor
  // CLEAR | one-cycle clear of MAC product and accumulator
  // RUN   | accepting operand beats, bubbles allowed
  // DRAIN | zero-operand beat flushes the product register into the accumulator
  // CAPT  | accumulator sampled into the result register
  // DONE  | result presented until accepted
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_CAPT  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [1:0]       r_prec;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_cnt;
  logic [55:0]      r_res_data;
  logic [1:0]       r_res_prec;
  logic             r_res_err;

  logic w_job_acc;
  logic w_beat;
  logic w_last;
  logic w_skip;
  logic w_rsvd;

  assign w_job_acc = (r_state == S_IDLE) && job_valid;
  assign w_beat    = (r_state == S_RUN) && op_valid;
  // Count stops one short of len, so the maximum length never overflows the counter.
  assign w_last    = w_beat && (r_cnt == (r_len - LEN_W'(1)));
  assign w_rsvd    = (r_prec == 2'b11);
  assign w_skip    = (r_len == '0) || w_rsvd;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_prec     <= 2'b00;
      r_len      <= '0;
      r_cnt      <= '0;
      r_res_data <= '0;
      r_res_prec <= 2'b00;
      r_res_err  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_job_acc) begin
        r_prec <= job_prec;
        r_len  <= job_len;
      end
      if (r_state == S_CLEAR) begin
        r_cnt <= '0;
      end else if (w_beat) begin
        r_cnt <= r_cnt + LEN_W'(1);
      end
      if (r_state == S_CAPT) begin
        r_res_data <= w_rsvd ? 56'd0 : mac_result;
        r_res_prec <= r_prec;
        r_res_err  <= w_rsvd;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (job_valid) w_next = S_CLEAR;
      S_CLEAR: w_next = w_skip ? S_DRAIN : S_RUN;
      S_RUN:   if (w_last) w_next = S_DRAIN;
      S_DRAIN: w_next = S_CAPT;
      S_CAPT:  w_next = S_DONE;
      S_DONE:  if (res_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    job_ready = 1'b0;
    op_ready  = 1'b0;
    mac_en    = 1'b0;
    mac_clr   = rst;
    mac_prec  = 2'b00;
    mac_act   = 8'd0;
    mac_wgt   = 8'd0;
    res_valid = 1'b0;
    unique case (r_state)
      S_IDLE:  job_ready = ~rst;
      S_CLEAR: begin
        mac_clr  = 1'b1;
        mac_prec = r_prec;
      end
      S_RUN: begin
        op_ready = 1'b1;
        mac_en   = op_valid;
        mac_act  = op_act;
        mac_wgt  = op_wgt;
        mac_prec = r_prec;
      end
      S_DRAIN: begin
        mac_en   = 1'b1;
        mac_prec = r_prec;
      end
      S_CAPT:  mac_prec = r_prec;
      S_DONE:  res_valid = 1'b1;
      default: job_ready = 1'b0;
    endcase
  end

  assign res_data = r_res_data;
  assign res_prec = r_res_prec;
  assign res_err  = r_res_err;
  assign busy     = (r_state != S_IDLE);

endmodule

// File: tb/tb_mac_sequencer.sv
// Scoreboarded bench for mac_sequencer with a lane-wise behavioural MAC attached.
module tb_mac_sequencer;

  localparam int LEN_W = 16;

  logic             clk;
  logic             rst;
  logic             job_valid;
  logic             job_ready;
  logic [1:0]       job_prec;
  logic [LEN_W-1:0] job_len;
  logic             op_valid;
  logic             op_ready;
  logic [7:0]       op_act;
  logic [7:0]       op_wgt;
  logic             mac_en;
  logic             mac_clr;
  logic [1:0]       mac_prec;
  logic [7:0]       mac_act;
  logic [7:0]       mac_wgt;
  logic [55:0]      mac_result;
  logic             res_valid;
  logic             res_ready;
  logic [55:0]      res_data;
  logic [1:0]       res_prec;
  logic             res_err;
  logic             busy;

  mac_sequencer #(.LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst),
    .job_valid(job_valid), .job_ready(job_ready), .job_prec(job_prec), .job_len(job_len),
    .op_valid(op_valid), .op_ready(op_ready), .op_act(op_act), .op_wgt(op_wgt),
    .mac_en(mac_en), .mac_clr(mac_clr), .mac_prec(mac_prec), .mac_act(mac_act), .mac_wgt(mac_wgt),
    .mac_result(mac_result),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_prec(res_prec),
    .res_err(res_err), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural MAC: product register feeding a lane-split accumulator.
  function automatic logic [55:0] mprod(input logic [1:0] p, input logic [7:0] a, input logic [7:0] w);
    logic signed [15:0] t;
    logic [55:0] r;
    r = '0;
    case (p)
      2'b01: begin
        t = $signed(a) * $signed(w[7:4]); r[55:28] = {{12{t[15]}}, t};
        t = $signed(a) * $signed(w[3:0]); r[27:0]  = {{12{t[15]}}, t};
      end
      2'b10: begin
        t = $signed(a) * $signed(w[7:6]); r[55:42] = t[13:0];
        t = $signed(a) * $signed(w[5:4]); r[41:28] = t[13:0];
        t = $signed(a) * $signed(w[3:2]); r[27:14] = t[13:0];
        t = $signed(a) * $signed(w[1:0]); r[13:0]  = t[13:0];
      end
      default: begin
        t = $signed(a) * $signed(w); r = {{40{t[15]}}, t};
      end
    endcase
    return r;
  endfunction

  function automatic logic [55:0] madd(input logic [1:0] p, input logic [55:0] x, input logic [55:0] y);
    case (p)
      2'b01:   return {x[55:28] + y[55:28], x[27:0] + y[27:0]};
      2'b10:   return {x[55:42] + y[55:42], x[41:28] + y[41:28], x[27:14] + y[27:14], x[13:0] + y[13:0]};
      default: return x + y;
    endcase
  endfunction

  logic [55:0] m_prod;
  logic [55:0] m_acc;
  always @(posedge clk) begin
    if (mac_clr) begin
      m_prod <= '0;
      m_acc  <= '0;
    end else if (mac_en) begin
      m_prod <= mprod(mac_prec, mac_act, mac_wgt);
      m_acc  <= madd(mac_prec, m_acc, m_prod);
    end
  end
  assign mac_result = m_acc;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic fail_to(input string nm);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got timeout expected event", nm);
  endtask

  typedef struct packed {
    logic [55:0] d;
    logic [1:0]  p;
    logic        e;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  always @(negedge clk) begin
    if (!rst && res_valid && res_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_result: got data %0h expected no result", res_data);
      end else begin
        mon_e = sb.pop_front();
        chk("res_data", 64'(res_data), 64'(mon_e.d));
        chk("res_prec", 64'(res_prec), 64'(mon_e.p));
        chk("res_err",  64'(res_err),  64'(mon_e.e));
      end
    end
  end

  int c_en, c_clr, c_opr;
  always @(negedge clk) begin
    if (!rst) begin
      c_en  += int'(mac_en);
      c_clr += int'(mac_clr);
      c_opr += int'(op_ready);
    end
  end

  task automatic do_job(input string nm, input logic [1:0] p, input logic [15:0] len,
                        input logic [7:0] a, input logic [7:0] w, input int gap, input int hold,
                        input logic [55:0] exp_d, input int exp_en);
    int to;
    int acc_cyc;
    bit skip;
    skip = (len == 0) || (p == 2'b11);
    sb.push_back('{d: exp_d, p: p, e: (p == 2'b11)});
    res_ready = (hold == 0);
    @(posedge clk); #1;
    c_en = 0; c_clr = 0; c_opr = 0;
    job_valid = 1'b1; job_prec = p; job_len = len;
    to = 0;
    @(negedge clk);
    while (!job_ready && to < 50) begin @(negedge clk); to++; end
    if (to >= 50) fail_to({nm, "_accept"});
    acc_cyc = cyc;
    @(posedge clk); #1;
    job_valid = 1'b0;
    @(negedge clk);
    chk({nm, "_clr_prec"}, 64'(mac_prec), 64'(p));
    if (skip) op_valid = 1'b1;
    for (int i = 0; i < int'(len) && !skip; i++) begin
      op_valid = 1'b1; op_act = a; op_wgt = w;
      to = 0;
      if (i != 0) @(negedge clk);
      while (!op_ready && to < 50) begin @(negedge clk); to++; end
      if (to >= 50) fail_to({nm, "_beat"});
      @(posedge clk); #1;
      op_valid = 1'b0;
      if (i < int'(len) - 1) repeat (gap) @(posedge clk);
      #1;
    end
    to = 0;
    @(negedge clk);
    while (!res_valid && to < 50) begin @(negedge clk); to++; end
    if (to >= 50) fail_to({nm, "_result"});
    op_valid = 1'b0;
    if (gap == 0) chk({nm, "_latency"}, 64'(cyc - acc_cyc), skip ? 64'd4 : 64'(len) + 64'd4);
    chk({nm, "_clr_cnt"}, 64'(c_clr), 64'd1);
    chk({nm, "_en_cnt"},  64'(c_en),  64'(exp_en));
    if (skip) chk({nm, "_opready_cnt"}, 64'(c_opr), 64'd0);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      job_valid = 1'b1; job_prec = 2'b00; job_len = 16'd3;
      @(negedge clk);
      chk({nm, "_hold_valid"}, 64'(res_valid), 64'd1);
      chk({nm, "_hold_data"},  64'(res_data),  64'(exp_d));
      chk({nm, "_hold_jready"}, 64'(job_ready), 64'd0);
    end
    if (hold > 0) begin
      @(posedge clk); #1;
      job_valid = 1'b0;
      res_ready = 1'b1;
      @(negedge clk);
    end
    @(posedge clk); #1;
    @(negedge clk);
    chk({nm, "_idle_busy"}, 64'(busy), 64'd0);
    chk({nm, "_idle_prec"}, 64'(mac_prec), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; job_valid = 1'b0; job_prec = 2'b00; job_len = '0;
    op_valid = 1'b0; op_act = 8'd0; op_wgt = 8'd0; res_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy",     64'(busy),      64'd0);
    chk("rst_resvalid", 64'(res_valid), 64'd0);
    chk("rst_opready",  64'(op_ready),  64'd0);
    chk("rst_macen",    64'(mac_en),    64'd0);
    chk("rst_macclr",   64'(mac_clr),   64'd1);
    chk("rst_resdata",  64'(res_data),  64'd0);
    chk("rst_reserr",   64'(res_err),   64'd0);
    chk("rst_resprec",  64'(res_prec),  64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_jready", 64'(job_ready), 64'd1);
    chk("post_rst_clr",    64'(mac_clr),   64'd0);

    do_job("full_len4",  2'b00, 16'd4, 8'd3,   8'd5,         0, 0, 56'd60, 5);
    do_job("p2_len1",    2'b10, 16'd1, 8'd1,   8'b01010111,  0, 0,
           {14'd1, 14'd1, 14'd1, 14'h3FFF}, 2);
    do_job("bubbles",    2'b00, 16'd3, 8'hFE,  8'd7,         2, 0, 56'hFF_FFFF_FFFF_FFD6, 4);
    do_job("len0",       2'b00, 16'd0, 8'd0,   8'd0,         0, 0, 56'd0, 1);
    do_job("rsvd_prec",  2'b11, 16'd5, 8'd9,   8'd9,         0, 0, 56'd0, 1);
    do_job("hold_done",  2'b01, 16'd2, 8'd2,   8'h3F,        0, 5,
           {28'd12, 28'hFFF_FFFC}, 3);

    // Abort a job after two of four beats; it must leave no result behind.
    @(posedge clk); #1;
    job_valid = 1'b1; job_prec = 2'b00; job_len = 16'd4;
    @(posedge clk); #1;
    job_valid = 1'b0;
    op_valid = 1'b1; op_act = 8'd3; op_wgt = 8'd5;
    repeat (3) @(posedge clk);
    #1;
    op_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("abort_busy",    64'(busy),     64'd0);
    chk("abort_macclr",  64'(mac_clr),  64'd1);
    chk("abort_opready", 64'(op_ready), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_jready", 64'(job_ready), 64'd1);
    do_job("after_abort", 2'b00, 16'd1, 8'd1, 8'd1, 0, 0, 56'd1, 2);

    repeat (3) @(posedge clk);
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
